// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT/FETCH/HOLD fetch control with branch, jump and register-jump redirects.
// Optional jr alignment checking is compiled in with `define PC_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic        br_req,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        j_req,
    input  logic [25:0] j_target,
    input  logic        jr_req,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        redirect,
    output logic        misalign_err
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc_nx;
    logic [31:0] pc_seq;
    logic [31:0] br_dest;
    logic [31:0] j_dest;
    logic [31:0] jr_dest;
    logic        redirect_nx;
    logic        err_nx;
    logic        jr_bad;

    assign pc_seq  = pc + 32'd4;
    assign br_dest = pc_seq + {{14{br_imm[15]}}, br_imm, 2'b00};
    assign j_dest  = {pc_seq[31:28], j_target, 2'b00};
    assign jr_dest = jr_addr & ~32'd3;

`ifdef PC_ALIGN_CHECK_EN
    assign jr_bad = jr_req && (jr_addr[1:0] != 2'b00);
`else
    assign jr_bad = 1'b0;
`endif

    assign fetch_valid = (state == FETCH);

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        redirect_nx = 1'b0;
        err_nx      = misalign_err;
        case (state)
            BOOT: state_nx = FETCH;
            FETCH, HOLD: begin
                if (jr_bad) begin
                    err_nx = 1'b1;
                end
                // A misaligned jr squashes every redirect source this cycle, not just itself.
                if (jr_req && !jr_bad) begin
                    pc_nx       = jr_dest;
                    redirect_nx = 1'b1;
                end else if (j_req && !jr_bad) begin
                    pc_nx       = j_dest;
                    redirect_nx = 1'b1;
                end else if (br_req && br_taken && !jr_bad) begin
                    pc_nx       = br_dest;
                    redirect_nx = 1'b1;
                end else if (state == HOLD) begin
                    if (!stall) begin
                        state_nx = FETCH;
                    end
                end else if (stall) begin
                    state_nx = HOLD;
                end else if (fetch_ready) begin
                    pc_nx = pc_seq;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            redirect     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            redirect     <= redirect_nx;
            misalign_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RST = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, stall, fetch_ready, br_req, br_taken, j_req, jr_req;
    logic [15:0] br_imm;
    logic [25:0] j_target;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic        fetch_valid, redirect, misalign_err;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_boot, m_hold, m_redirect, m_err;

    pc_sequencer #(.RESET_PC(RST)) dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .br_req(br_req), .br_taken(br_taken), .br_imm(br_imm),
        .j_req(j_req), .j_target(j_target), .jr_req(jr_req), .jr_addr(jr_addr),
        .pc(pc), .fetch_valid(fetch_valid), .redirect(redirect), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; stall = 0; fetch_ready = 1;
        br_req = 0; br_taken = 0; br_imm = '0;
        j_req = 0; j_target = '0; jr_req = 0; jr_addr = '0;
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_edge();
        logic [31:0] seq, dest;
        bit bad, take;
        if (reset) begin
            m_pc = RST; m_boot = 1; m_hold = 0; m_redirect = 0; m_err = 0;
            return;
        end
        m_redirect = 0;
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        seq  = m_pc + 4;
        bad  = 0;
`ifdef PC_ALIGN_CHECK_EN
        bad = jr_req && (jr_addr % 4 != 0);
`endif
        if (bad) m_err = 1;
        take = 0;
        dest = m_pc;
        if (!bad) begin
            if (jr_req) begin
                dest = jr_addr - (jr_addr % 4); take = 1;
            end else if (j_req) begin
                dest = (seq & 32'hF000_0000) | (32'(j_target) * 4); take = 1;
            end else if (br_req && br_taken) begin
                dest = seq + 32'($signed(br_imm) * 4); take = 1;
            end
        end
        if (take) begin
            m_pc = dest; m_redirect = 1;
        end else if (m_hold) begin
            m_hold = stall;
        end else if (stall) begin
            m_hold = 1;
        end else if (fetch_ready) begin
            m_pc = seq;
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(!m_boot && !m_hold));
        check({tag, ".redirect"}, 32'(redirect), 32'(m_redirect));
        check({tag, ".misalign_err"}, 32'(misalign_err), 32'(m_err));
    endtask

    task automatic do_reset();
        idle(); reset = 1;
        step("reset");
        idle();
    endtask

    task automatic jr_to(input logic [31:0] a);
        idle(); jr_req = 1; jr_addr = a;
        step("jr_to");
        check("jr_to.pc_const", pc, a);
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        step("reset0");
        step("reset1");
        check("reset.pc_const", pc, RST);
        check("reset.fv_const", 32'(fetch_valid), 32'd0);
        idle();

        // Boot then sequential fetch
        step("boot");
        check("boot.pc", pc, 32'h0040_0000);
        step("seq1");
        check("seq1.pc", pc, 32'h0040_0004);
        step("seq2");
        check("seq2.pc", pc, 32'h0040_0008);

        // Backward taken branch, then not-taken branch
        jr_to(32'h0000_1000);
        br_req = 1; br_taken = 1; br_imm = 16'hFFFE;
        step("br_taken");
        check("br_taken.pc", pc, 32'h0000_0FFC);
        check("br_taken.pulse", 32'(redirect), 32'd1);
        idle();
        step("br_pulse_end");
        check("br_pulse_end.pulse", 32'(redirect), 32'd0);
        jr_to(32'h0000_1000);
        br_req = 1; br_taken = 0; br_imm = 16'hFFFE;
        step("br_not_taken");
        check("br_not_taken.pc", pc, 32'h0000_1004);
        check("br_not_taken.pulse", 32'(redirect), 32'd0);

        // Jump beats simultaneous taken branch
        jr_to(32'h3000_0010);
        j_req = 1; j_target = 26'h0000100; br_req = 1; br_taken = 1; br_imm = 16'h0040;
        step("jump_prio");
        check("jump_prio.pc", pc, 32'h3000_0400);

        // Stall hold with jump during HOLD
        jr_to(32'h0000_0020);
        stall = 1;
        for (int i = 0; i < 3; i++) step("stall");
        check("stall.pc", pc, 32'h0000_0020);
        check("stall.fv", 32'(fetch_valid), 32'd0);
        j_req = 1; j_target = 26'h10;
        step("hold_jump");
        check("hold_jump.pc", pc, 32'h0000_0040);
        check("hold_jump.fv", 32'(fetch_valid), 32'd0);
        j_req = 0;
        step("hold_stay");
        stall = 0;
        step("unstall");
        check("unstall.pc", pc, 32'h0000_0040);
        check("unstall.fv", 32'(fetch_valid), 32'd1);

        // Unaccepted fetch is held stable
        fetch_ready = 0;
        step("not_ready");
        check("not_ready.pc", pc, 32'h0000_0040);

        // Misaligned register jump
        idle(); jr_req = 1; jr_addr = 32'h0000_0102; j_req = 1; j_target = 26'h3;
        step("jr_misalign");
`ifdef PC_ALIGN_CHECK_EN
        check("jr_misalign.err", 32'(misalign_err), 32'd1);
        check("jr_misalign.pulse", 32'(redirect), 32'd0);
        idle();
        step("err_sticky");
        check("err_sticky.err", 32'(misalign_err), 32'd1);
`else
        check("jr_misalign.pc", pc, 32'h0000_0100);
        check("jr_misalign.pulse", 32'(redirect), 32'd1);
        check("jr_misalign.err", 32'(misalign_err), 32'd0);
        idle();
`endif

        // Wrap at top of address space, then reset beats redirect
        jr_to(32'hFFFF_FFFC);
        step("wrap");
        check("wrap.pc", pc, 32'h0000_0000);
        jr_req = 1; jr_addr = 32'h0000_8000; stall = 1; reset = 1;
        step("reset_vs_redirect");
        check("reset_vs_redirect.pc", pc, RST);
        check("reset_vs_redirect.pulse", 32'(redirect), 32'd0);
        idle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 49) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            br_req      = ($urandom_range(0, 4) == 0);
            br_taken    = $urandom_range(0, 1) == 1;
            br_imm      = 16'($urandom);
            j_req       = ($urandom_range(0, 9) == 0);
            j_target    = 26'($urandom);
            jr_req      = ($urandom_range(0, 11) == 0);
            jr_addr     = $urandom;
            step("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  pipeline hold request from downstream.
REQ-005 fetch_ready  input  1  instruction memory accepts the current fetch.
REQ-006 br_req  input  1  branch resolved this cycle.
REQ-007 br_taken  input  1  branch outcome; meaningful only with br_req.
REQ-008 br_imm  input  16  branch word offset, two's complement.
REQ-009 j_req  input  1  absolute jump request.
REQ-010 j_target  input  26  jump word index.
REQ-011 jr_req  input  1  register jump request.
REQ-012 jr_addr  input  32  register jump byte address.
REQ-013 pc  output  32  current fetch address.
REQ-014 fetch_valid  output  1  pc is a valid fetch request.
REQ-015 redirect  output  1  one-cycle pulse: PC was replaced by a redirect on the previous edge.
REQ-016 misalign_err  output  1  sticky jr misalignment flag (see Configuration).

Function
REQ-017 States: BOOT, FETCH, HOLD; fetch_valid SHALL be 1 only in FETCH.
REQ-018 BOOT -> FETCH unconditionally after one cycle; redirects and stall ignored in BOOT.
REQ-019 FETCH, fetch_ready=1, stall=0, no redirect: pc <= pc+4, stay FETCH.
REQ-020 FETCH, stall=1: go HOLD, pc unchanged, even if fetch_ready=1.
REQ-021 FETCH, fetch_ready=0, stall=0: pc and fetch_valid held stable.
REQ-022 HOLD -> FETCH when stall=0; pc unchanged on that transition.
REQ-023 Redirect effective when jr_req, or j_req, or (br_req and br_taken); priority jr > j > branch.
REQ-024 Branch target = pc + 4 + (sign-extended br_imm shifted left 2), modulo 2^32.
REQ-025 Jump target = {(pc+4)[31:28], j_target, 2'b00}.
REQ-026 Redirect in FETCH or HOLD SHALL load target next edge, override pc+4 even when fetch_ready=1 same cycle, and not change state.
REQ-027 Redirect cancels an unaccepted fetch; the new pc is presented with fetch_valid unchanged.
REQ-028 br_req with br_taken=0 SHALL be ignored (no redirect pulse).
REQ-029 pc+4 at 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.

Reset
REQ-030 On reset: pc=RESET_PC, state=BOOT, fetch_valid=0, redirect=0, misalign_err=0.
REQ-031 Reset SHALL dominate all other inputs, including mid-redirect and mid-stall.

Configuration
REQ-032 Macro PC_ALIGN_CHECK_EN defined: jr_req with jr_addr[1:0]!=0 SHALL set misalign_err (sticky until reset) and suppress the whole redirect (no lower-priority redirect, no pulse, pc advances per REQ-019..022).
REQ-033 Macro undefined: jr target = {jr_addr[31:2], 2'b00}; misalign_err tied 0.

Verification
REQ-034 Reset with RESET_PC=32'h0040_0000, fetch_ready=1 -> BOOT one cycle, then pc 0x00400000, 0x00400004, 0x00400008 on successive cycles.
REQ-035 pc=0x00001000, br_req=1, br_taken=1, br_imm=16'hFFFE -> pc=0x00000FFC, redirect pulse 1 cycle; br_taken=0 -> pc=0x00001004, no pulse.
REQ-036 pc=0x30000010, j_req=1, j_target=26'h0000100 and br taken same cycle -> pc=0x30000400 (jump wins).
REQ-037 stall=1 for 3 cycles with fetch_ready=1 at pc=0x20 -> fetch_valid 0, pc stays 0x20; j_req during HOLD with j_target=26'h10 -> pc=0x00000040, state HOLD until stall drops.
REQ-038 jr_req=1, jr_addr=0x00000102: with PC_ALIGN_CHECK_EN -> misalign_err=1 sticky, no redirect; without -> pc=0x00000100, redirect pulse.
REQ-039 pc=0xFFFFFFFC, fetch_ready=1 -> pc=0x00000000; reset asserted same cycle as redirect -> pc=RESET_PC.
